// File: rtl/classifier_pkg.sv
// Shared definitions for the classifier fetch path: reader FSM states and
// default SRAM geometry.
package classifier_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy count. A push
// never reaches the head in the same cycle (no write-through).
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign empty    = (count_reg == '0);

endmodule

// File: rtl/sram_pair_reader.sv
// Streams NUM_WORDS locations from a lockstep pair of read-only SRAM banks
// into a small FIFO and hands {bank2,bank1} pairs to the core over valid/ready.
module sram_pair_reader
  import classifier_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_WORDS  = 4,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                learn,
  output logic [ADDR_W-1:0]   MEM_ADD1,
  output logic [ADDR_W-1:0]   MEM_ADD2,
  output logic                MEM_CSB1,
  output logic                MEM_CSB2,
  output logic                MEM_OEB1,
  output logic                MEM_OEB2,
  output logic                MEM_WEB1,
  output logic                MEM_WEB2,
  input  logic [DATA_W-1:0]   DATA_I1,
  input  logic [DATA_W-1:0]   DATA_I2,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int PAIR_W  = 2 * DATA_W;
  localparam int ENTRY_W = PAIR_W + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + NUM_WORDS - 1);

  state_t             state_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic               issue;
  logic               pop;

  // Read data lands at the edge closing the issue cycle, so nothing is still
  // in flight when the next issue is decided; the occupancy check ignores the
  // same-cycle pop to stay conservative.
  assign issue = (state_reg == READ) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign pop   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= FIRST_ADDR;
    end else begin
      case (state_reg)
        IDLE: begin
          if (learn) begin
            state_reg <= READ;
            addr_reg  <= FIRST_ADDR;
          end
        end
        READ: begin
          if (issue) begin
            addr_reg <= addr_reg + 1'b1;
            if (addr_reg == LAST_ADDR) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The tagged pair is the final FIFO entry, so its acceptance empties it.
          if (pop && out_last) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          addr_reg  <= FIRST_ADDR;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data ({(addr_reg == LAST_ADDR), DATA_I2, DATA_I1}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head[PAIR_W-1:0];
  assign out_last  = head[ENTRY_W-1] && !fifo_empty;

  assign MEM_ADD1 = addr_reg;
  assign MEM_ADD2 = addr_reg;
  assign MEM_CSB1 = !issue;
  assign MEM_CSB2 = !issue;
  assign MEM_OEB1 = !issue;
  assign MEM_OEB2 = !issue;
  assign MEM_WEB1 = 1'b1;
  assign MEM_WEB2 = 1'b1;

  assign busy = (state_reg == READ) || (state_reg == DRAIN);
  assign done = (state_reg == DONE);

endmodule
